pulse_sync_rx_multi: RTL and testbench

- Multi-channel receive half of a toggle-based pulse synchroniser; parametrised successor to the single-channel clk_a/clk_b pulse sync.
- Per channel: samples an asynchronous toggle line through a SYNC_STAGES flop chain and edge-detects it.
- Each detected edge is queued in a saturating pending counter. The counter drains as one-cycle output pulses with guaranteed minimum spacing.
- Sits in the destination clock domain; the source side only flips one toggle wire per event.

---
 rtl/pulse_sync_pkg.sv | 19 +
 rtl/pulse_sync_rx_chan.sv | 98 +++++++++
 rtl/pulse_sync_rx_multi.sv | 63 ++++++
 tb/tb_pulse_sync_rx_multi.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sync_pkg.sv
// Shared types and helpers for the multi-channel toggle pulse synchroniser (receive side).
package pulse_sync_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } state_t;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  // Cycles of edge masking after reset so a level held through reset is not seen as an event.
  function automatic int warm_len(input int stages);
    return stages + 1;
  endfunction

endpackage

// File: rtl/pulse_sync_rx_chan.sv
// One receive channel: toggle synchroniser, edge detect, saturating pending counter and pulse FSM.
// Optional return toggle under PULSE_SYNC_RX_ACK_EN.
module pulse_sync_rx_chan
  import pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3,
  parameter int GAP         = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic toggle,
  input  logic ovf_clr,
  input  logic warm_done,
  output logic pulse,
  output logic pending,
  output logic ovf,
  output logic active
`ifdef PULSE_SYNC_RX_ACK_EN
  ,
  output logic ack_toggle
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [GW-1:0]          gap_cnt;
  state_t                 state;
  logic                   evt;
  logic                   issue;
  logic                   drop;

  always_comb begin
    evt   = (sync[SYNC_STAGES-1] ^ hist) & warm_done;
    issue = 1'b0;
    case (state)
      S_IDLE:  issue = (cnt != '0);
      S_PULSE: issue = (GAP == 0) && (cnt != '0);
      S_GAP:   issue = (gap_cnt == '0) && (cnt != '0);
      default: issue = 1'b0;
    endcase
    drop    = evt && !issue && (cnt == CNT_MAX);
    cnt_nxt = cnt;
    if (evt && !issue && !drop) cnt_nxt = cnt + 1'b1;
    else if (!evt && issue)     cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= '0;
      hist       <= 1'b0;
      cnt        <= '0;
      pending    <= 1'b0;
      ovf        <= 1'b0;
      gap_cnt    <= '0;
      state      <= S_IDLE;
`ifdef PULSE_SYNC_RX_ACK_EN
      ack_toggle <= 1'b0;
`endif
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], toggle};
      hist    <= sync[SYNC_STAGES-1];
      cnt     <= cnt_nxt;
      pending <= (cnt_nxt != '0);
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
`ifdef PULSE_SYNC_RX_ACK_EN
      if (issue) ack_toggle <= ~ack_toggle;
`endif
      case (state)
        S_IDLE:  if (issue) state <= S_PULSE;
        S_PULSE: begin
          if (GAP > 0) begin
            state   <= S_GAP;
            gap_cnt <= GW'(GAP - 1);
          end else begin
            state <= issue ? S_PULSE : S_IDLE;
          end
        end
        // Last gap cycle issues directly so back-to-back events sustain one pulse per GAP+1 cycles.
        S_GAP: begin
          if (gap_cnt == '0) state <= issue ? S_PULSE : S_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pulse  = (state == S_PULSE);
  assign active = (state != S_IDLE);

endmodule

// File: rtl/pulse_sync_rx_multi.sv
// Multi-channel receive half of a toggle pulse synchroniser: shared warm-up mask and busy reduction.
// Define PULSE_SYNC_RX_ACK_EN to add the per-channel ack_toggle_o return toggles.
module pulse_sync_rx_multi
  import pulse_sync_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3,
  parameter int GAP         = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] toggle_i,
  input  logic [CHANNELS-1:0] ovf_clr_i,
  output logic [CHANNELS-1:0] pulse_o,
  output logic [CHANNELS-1:0] pending_o,
  output logic [CHANNELS-1:0] ovf_o,
  output logic                busy_o
`ifdef PULSE_SYNC_RX_ACK_EN
  ,
  output logic [CHANNELS-1:0] ack_toggle_o
`endif
);

  localparam int WL = warm_len(SYNC_STAGES);
  localparam int WW = $clog2(WL + 1);

  logic [WW-1:0]       warm_cnt;
  logic                warm_done;
  logic [CHANNELS-1:0] active;

  assign warm_done = (warm_cnt == WW'(WL));

  always_ff @(posedge clk) begin
    if (rst)             warm_cnt <= '0;
    else if (!warm_done) warm_cnt <= warm_cnt + 1'b1;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pulse_sync_rx_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W),
      .GAP        (GAP)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .toggle    (toggle_i[i]),
      .ovf_clr   (ovf_clr_i[i]),
      .warm_done (warm_done),
      .pulse     (pulse_o[i]),
      .pending   (pending_o[i]),
      .ovf       (ovf_o[i]),
      .active    (active[i])
`ifdef PULSE_SYNC_RX_ACK_EN
      ,
      .ack_toggle(ack_toggle_o[i])
`endif
    );
  end

  assign busy_o = (|pending_o) | (|active);

endmodule

// File: tb/tb_pulse_sync_rx_multi.sv
// Scoreboard bench for pulse_sync_rx_multi at default parameters (4 ch, 2 stages, CNT_W=3, GAP=1).
module tb_pulse_sync_rx_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] toggle_i;
  logic [3:0] ovf_clr_i;
  logic [3:0] pulse_o;
  logic [3:0] pending_o;
  logic [3:0] ovf_o;
  logic       busy_o;
`ifdef PULSE_SYNC_RX_ACK_EN
  logic [3:0] ack_toggle_o;
`endif

  pulse_sync_rx_multi #(
    .CHANNELS   (4),
    .SYNC_STAGES(2),
    .CNT_W      (3),
    .GAP        (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .toggle_i    (toggle_i),
    .ovf_clr_i   (ovf_clr_i),
    .pulse_o     (pulse_o),
    .pending_o   (pending_o),
    .ovf_o       (ovf_o),
    .busy_o      (busy_o)
`ifdef PULSE_SYNC_RX_ACK_EN
    ,
    .ack_toggle_o(ack_toggle_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ch;
    int at;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input int ch, input int at);
    exp_t e;
    e.ch = ch;
    e.at = at;
    sb.push_back(e);
  endtask

  // Pulses expected in cycle 'now' are removed from the scoreboard and returned as a mask.
  function automatic logic [3:0] pop_due(input int now);
    logic [3:0] m;
    int i;
    m = '0;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].at == now) begin
        m[sb[i].ch] = 1'b1;
        sb.delete(i);
      end else begin
        i++;
      end
    end
    return m;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] e;
    repeat (3) tick();
    checks++;
    if ({pulse_o, pending_o, ovf_o, busy_o} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: pulse=%b pending=%b ovf=%b busy=%b required all 0",
               pulse_o, pending_o, ovf_o, busy_o);
    end
`ifdef PULSE_SYNC_RX_ACK_EN
    checks++;
    if (ack_toggle_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ack: ack=%b required 0000", ack_toggle_o);
    end
`endif
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      e = pop_due(cyc);
      checks++;
      if ({pulse_o, pending_o, ovf_o, busy_o} !== {e, 9'd0}) begin
        errors++;
        $display("FAIL held_level_quiet cyc %0d: pulse=%b pending=%b ovf=%b busy=%b required all 0",
                 cyc, pulse_o, pending_o, ovf_o, busy_o);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] e;
    int c;
    c = cyc;
    toggle_i[0] = ~toggle_i[0];
    push_exp(0, c + 4);
    for (int n = 0; n < 10; n++) begin
      tick();
      e = pop_due(cyc);
      checks++;
      if (pulse_o !== e) begin
        errors++;
        $display("FAIL single_pulse cyc %0d: pulse_o=%b required %b", cyc, pulse_o, e);
      end
      if (cyc == c + 2 || cyc == c + 3 || cyc == c + 4) begin
        checks++;
        if (pending_o[0] !== (cyc == c + 3)) begin
          errors++;
          $display("FAIL single_pending cyc %0d: pending_o[0]=%b required %b",
                   cyc, pending_o[0], (cyc == c + 3));
        end
      end
    end
    checks++;
    if (busy_o !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL single_done: busy_o=%b left=%0d required busy 0 left 0", busy_o, sb.size());
    end
`ifdef PULSE_SYNC_RX_ACK_EN
    checks++;
    if (ack_toggle_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_ack: ack_toggle_o[0]=%b required 1", ack_toggle_o[0]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    int c;
    c = cyc;
    for (int n = 0; n < 16; n++) begin
      if (n < 3) begin
        toggle_i[1] = ~toggle_i[1];
        push_exp(1, c + 4 + 2 * n);
      end
      tick();
      e = pop_due(cyc);
      checks++;
      if (pulse_o !== e) begin
        errors++;
        $display("FAIL b2b_pulse cyc %0d: pulse_o=%b required %b", cyc, pulse_o, e);
      end
      if (cyc == c + 7 || cyc == c + 8) begin
        checks++;
        if (pending_o[1] !== (cyc == c + 7)) begin
          errors++;
          $display("FAIL b2b_pending cyc %0d: pending_o[1]=%b required %b",
                   cyc, pending_o[1], (cyc == c + 7));
        end
      end
    end
    checks++;
    if (sb.size() != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: left=%0d busy=%b required 0 0", sb.size(), busy_o);
    end
  endtask

  // 20 back-to-back events: 17 accepted (pulses every 2 cycles), drops at c+17, c+19, c+21.
  task automatic test_overflow(input bit clr_on_drop);
    logic [3:0] e;
    int c;
    c = cyc;
    for (int j = 0; j < 17; j++) push_exp(2, c + 4 + 2 * j);
    for (int n = 0; n < 46; n++) begin
      if (n < 20) toggle_i[2] = ~toggle_i[2];
      if (clr_on_drop && n == 16) ovf_clr_i[2] = 1'b1;
      if (n == 17) ovf_clr_i[2] = 1'b0;
      tick();
      e = pop_due(cyc);
      checks++;
      if (pulse_o !== e) begin
        errors++;
        $display("FAIL ovf_pulse cyc %0d: pulse_o=%b required %b", cyc, pulse_o, e);
      end
      if (cyc == c + 16 || cyc == c + 17) begin
        checks++;
        if (ovf_o[2] !== (cyc == c + 17)) begin
          errors++;
          $display("FAIL ovf_set cyc %0d clr=%0d: ovf_o[2]=%b required %b",
                   cyc, clr_on_drop, ovf_o[2], (cyc == c + 17));
        end
      end
    end
    checks++;
    if (ovf_o[2] !== 1'b1 || pending_o[2] !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL ovf_drained: ovf=%b pending=%b left=%0d required 1 0 0",
               ovf_o[2], pending_o[2], sb.size());
    end
    ovf_clr_i[2] = 1'b1;
    tick();
    ovf_clr_i[2] = 1'b0;
    checks++;
    if (ovf_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf_o[2]=%b required 0", ovf_o[2]);
    end
  endtask

  task automatic test_all_channels();
    logic [3:0] e;
    int c;
    c = cyc;
    toggle_i = ~toggle_i;
    for (int ch = 0; ch < 4; ch++) push_exp(ch, c + 4);
    for (int n = 0; n < 10; n++) begin
      tick();
      e = pop_due(cyc);
      checks++;
      if (pulse_o !== e) begin
        errors++;
        $display("FAIL all_ch_pulse cyc %0d: pulse_o=%b required %b", cyc, pulse_o, e);
      end
    end
    checks++;
    if (sb.size() != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL all_ch_done: left=%0d busy=%b required 0 0", sb.size(), busy_o);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [3:0] e;
    int c;
    c = cyc;
    push_exp(3, c + 4);
    push_exp(3, c + 6);
    for (int n = 0; n < 31; n++) begin
      if (n < 5) toggle_i[3] = ~toggle_i[3];
      if (n == 6) rst = 1'b1;
      if (n == 7) rst = 1'b0;
      tick();
      e = pop_due(cyc);
      checks++;
      if (pulse_o !== e) begin
        errors++;
        $display("FAIL rst_drain_pulse cyc %0d: pulse_o=%b required %b", cyc, pulse_o, e);
      end
      if (cyc == c + 7) begin
        checks++;
        if (pending_o !== 4'b0000 || busy_o !== 1'b0) begin
          errors++;
          $display("FAIL rst_drain_clear: pending=%b busy=%b required 0000 0", pending_o, busy_o);
        end
`ifdef PULSE_SYNC_RX_ACK_EN
        checks++;
        if (ack_toggle_o !== 4'b0000) begin
          errors++;
          $display("FAIL rst_drain_ack: ack=%b required 0000", ack_toggle_o);
        end
`endif
      end
    end
    checks++;
    if (pending_o !== 4'b0000 || busy_o !== 1'b0 || ovf_o !== 4'b0000 || sb.size() != 0) begin
      errors++;
      $display("FAIL rst_drain_end: pending=%b busy=%b ovf=%b left=%0d required 0000 0 0000 0",
               pending_o, busy_o, ovf_o, sb.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    toggle_i  = 4'b1010;
    ovf_clr_i = 4'b0000;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow(1'b0);
    test_overflow(1'b1);
    test_all_channels();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
